// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon initialization engine.
// Holds the variant select enum, engine FSM states, the 320-bit state struct,
// the four initialization vectors, the p^a round-constant table and small helpers.
package ascon_pkg;

  typedef enum logic [1:0] {
    ASCON_128  = 2'd0,
    ASCON_128A = 2'd1,
    ASCON_HASH = 2'd2,
    ASCON_XOF  = 2'd3
  } ascon_sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } eng_state_e;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam logic [63:0] IV_128  = 64'h80400c0600000000;
  localparam logic [63:0] IV_128A = 64'h80800c0800000000;
  localparam logic [63:0] IV_HASH = 64'h00400c0000000100;
  localparam logic [63:0] IV_XOF  = 64'h00400c0000000000;

  localparam int unsigned NumRounds = 12;

  // Entry i is {4'hF-i, 4'h0+i}; index 0 sits in the low byte.
  localparam logic [11:0][7:0] RoundConst = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
    8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
  };

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Initial state before the permutation; key/nonce only matter for the AEAD variants.
  function automatic ascon_state_t init_state(input ascon_sel_e sel,
                                              input logic [127:0] key,
                                              input logic [127:0] nonce);
    ascon_state_t s;
    s = '0;
    case (sel)
      ASCON_128, ASCON_128A: begin
        s.x0 = (sel == ASCON_128) ? IV_128 : IV_128A;
        s.x1 = key[127:64];
        s.x2 = key[63:0];
        s.x3 = nonce[127:64];
        s.x4 = nonce[63:0];
      end
      ASCON_HASH: s.x0 = IV_HASH;
      default:    s.x0 = IV_XOF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round.
// Ports:
//   state_i  : 320-bit state entering the round
//   round_i  : absolute round index 0..11 (selects the round constant)
//   state_o  : state after constant addition, S-box layer and linear layer
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   round_i,
  output ascon_state_t state_o
);

  logic [7:0]  rc;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    rc = (round_i < 4'd12) ? RoundConst[round_i] : 8'h00;

    x0 = state_i.x0;
    x1 = state_i.x1;
    x2 = state_i.x2 ^ {56'h0, rc};
    x3 = state_i.x3;
    x4 = state_i.x4;

    // Bitsliced 5-bit S-box: input mixing, chi-like core, output mixing.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o.x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    state_o.x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    state_o.x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    state_o.x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    state_o.x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  end

endmodule

// File: rtl/ascon_init_engine.sv
// Ascon initialization engine: builds the initial state from key/nonce/variant,
// runs p^a with ROUNDS_PER_CYCLE unrolled rounds per clock, applies the AEAD key
// finalisation and holds the result under a valid/ready handshake.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o : request handshake
//   sel_type_i              : 0=Ascon-128, 1=Ascon-128a, 2=Hash, 3=XOF
//   key_i, nonce_i          : 128-bit key and nonce (ignored for Hash/XOF)
//   out_valid_o/out_ready_i : result handshake
//   out_type_o              : variant of the held result
//   x0_o..x4_o              : state words (working registers, qualified by out_valid_o)
//   busy_o                  : permutation in progress
module ascon_init_engine
  import ascon_pkg::*;
#(
  parameter int unsigned PA_ROUNDS        = 12,
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned KEY_W            = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       sel_type_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [KEY_W-1:0] nonce_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_type_o,
  output logic [63:0]      x0_o,
  output logic [63:0]      x1_o,
  output logic [63:0]      x2_o,
  output logic [63:0]      x3_o,
  output logic [63:0]      x4_o,
  output logic             busy_o
);

  if (KEY_W != 128) begin : g_bad_key_w
    $fatal(1, "ascon_init_engine: KEY_W must be 128");
  end
  if (PA_ROUNDS < 1 || PA_ROUNDS > NumRounds) begin : g_bad_pa_rounds
    $fatal(1, "ascon_init_engine: PA_ROUNDS must be 1..12");
  end
  if (ROUNDS_PER_CYCLE < 1 || (PA_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
    $fatal(1, "ascon_init_engine: ROUNDS_PER_CYCLE must divide PA_ROUNDS");
  end

  localparam logic [3:0] RcntInit = 4'(NumRounds - PA_ROUNDS);
  localparam logic [3:0] RcntStep = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] RcntLast = 4'(NumRounds);

  eng_state_e   state_q, state_d;
  logic [3:0]   rcnt_q, rcnt_d;
  ascon_state_t st_q, st_d;
  ascon_sel_e   sel_q, sel_d;
  logic [127:0] key_q, key_d;
  // Registered IDLE decode: holds in_ready low for the first cycle after reset.
  logic         idle_q;
  logic         accept;
  logic         last_cycle;
  ascon_state_t rounds_out;

  // Unrolled round chain; each stage uses round index rcnt_q + r.
  for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
    ascon_state_t st_in;
    ascon_state_t st_out;
    logic [3:0]   idx;
    if (r == 0) begin : g_first
      assign st_in = st_q;
    end else begin : g_next
      assign st_in = g_round[r-1].st_out;
    end
    assign idx = rcnt_q + 4'(r);
    ascon_round u_round (
      .state_i (st_in),
      .round_i (idx),
      .state_o (st_out)
    );
  end
  assign rounds_out = g_round[ROUNDS_PER_CYCLE-1].st_out;

  assign in_ready_o  = idle_q || ((state_q == StDone) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign last_cycle  = ((rcnt_q + RcntStep) == RcntLast);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StRun);
  assign out_type_o  = sel_q;
  assign x0_o        = st_q.x0;
  assign x1_o        = st_q.x1;
  assign x2_o        = st_q.x2;
  assign x3_o        = st_q.x3;
  assign x4_o        = st_q.x4;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    st_d    = st_q;
    sel_d   = sel_q;
    key_d   = key_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        st_d   = rounds_out;
        rcnt_d = rcnt_q + RcntStep;
        if (last_cycle) begin
          if (sel_q == ASCON_128 || sel_q == ASCON_128A) begin
            st_d.x3 = rounds_out.x3 ^ key_q[127:64];
            st_d.x4 = rounds_out.x4 ^ key_q[63:0];
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides DONE->IDLE so back-to-back requests go straight to RUN.
    if (accept) begin
      sel_d   = ascon_sel_e'(sel_type_i);
      key_d   = key_i;
      st_d    = init_state(ascon_sel_e'(sel_type_i), key_i, nonce_i);
      rcnt_d  = RcntInit;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      st_q    <= '0;
      sel_q   <= ASCON_128;
      key_q   <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      st_q    <= st_d;
      sel_q   <= sel_d;
      key_q   <= key_d;
      idle_q  <= (state_d == StIdle);
    end
  end

endmodule

// File: tb/tb_ascon_init_engine.sv
// Directed bench for ascon_init_engine: one RPC=1 instance for handshake/reset
// scenarios plus five instances (RPC 2,3,4,6,12) sharing a request bus.
module tb_ascon_init_engine;

  // Ascon 5-bit S-box, entry 0 in the low bits.
  localparam logic [159:0] SboxPack = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };
  localparam logic [319:0] HashExp = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };
  localparam logic [127:0] KeySeq = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Main instance (RPC=1)
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [1:0]   sel = 2'd0, out_type;
  logic [127:0] key = '0, nonce = '0;
  logic [63:0]  x0, x1, x2, x3, x4;

  ascon_init_engine #(.PA_ROUNDS(12), .ROUNDS_PER_CYCLE(1), .KEY_W(128)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sel_type_i  (sel),
    .key_i       (key),
    .nonce_i     (nonce),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_type_o  (out_type),
    .x0_o        (x0),
    .x1_o        (x1),
    .x2_o        (x2),
    .x3_o        (x3),
    .x4_o        (x4),
    .busy_o      (busy)
  );

  // Multi-RPC instances
  function automatic int unsigned rpc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      default: return 12;
    endcase
  endfunction

  logic         m_in_valid = 1'b0, m_out_ready = 1'b0;
  logic [1:0]   m_sel = 2'd0;
  logic [127:0] m_key = '0, m_nonce = '0;
  logic         a_in_ready [5];
  logic         a_ov [5];
  logic         a_busy [5];
  logic [1:0]   a_type [5];
  logic [63:0]  a_x [5][5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    ascon_init_engine #(.PA_ROUNDS(12), .ROUNDS_PER_CYCLE(rpc_of(g)), .KEY_W(128)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (m_in_valid),
      .in_ready_o  (a_in_ready[g]),
      .sel_type_i  (m_sel),
      .key_i       (m_key),
      .nonce_i     (m_nonce),
      .out_valid_o (a_ov[g]),
      .out_ready_i (m_out_ready),
      .out_type_o  (a_type[g]),
      .x0_o        (a_x[g][0]),
      .x1_o        (a_x[g][1]),
      .x2_o        (a_x[g][2]),
      .x3_o        (a_x[g][3]),
      .x4_o        (a_x[g][4]),
      .busy_o      (a_busy[g])
    );
  end

  // Reference permutation: table-driven S-box per bit column.
  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ref_perm(input logic [1:0] s, input logic [127:0] k,
                                            input logic [127:0] n);
    logic [63:0]  w [5];
    logic [63:0]  nw [5];
    logic [159:0] tab;
    logic [4:0]   col, sv;
    tab = SboxPack;
    for (int i = 0; i < 5; i++) w[i] = '0;
    case (s)
      2'd0: w[0] = 64'h80400c0600000000;
      2'd1: w[0] = 64'h80800c0800000000;
      2'd2: w[0] = 64'h00400c0000000100;
      default: w[0] = 64'h00400c0000000000;
    endcase
    if (s < 2'd2) begin
      w[1] = k[127:64]; w[2] = k[63:0]; w[3] = n[127:64]; w[4] = n[63:0];
    end
    for (int r = 0; r < 12; r++) begin
      w[2][7:0] = w[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
        sv = tab[5*int'(col) +: 5];
        for (int i = 0; i < 5; i++) nw[i][b] = sv[4-i];
      end
      w[0] = nw[0] ^ rotr(nw[0], 19) ^ rotr(nw[0], 28);
      w[1] = nw[1] ^ rotr(nw[1], 61) ^ rotr(nw[1], 39);
      w[2] = nw[2] ^ rotr(nw[2], 1)  ^ rotr(nw[2], 6);
      w[3] = nw[3] ^ rotr(nw[3], 10) ^ rotr(nw[3], 17);
      w[4] = nw[4] ^ rotr(nw[4], 7)  ^ rotr(nw[4], 41);
    end
    if (s < 2'd2) begin
      w[3] = w[3] ^ k[127:64];
      w[4] = w[4] ^ k[63:0];
    end
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for out_valid on the main instance; lat = edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic chk_words(input string tag, input logic [319:0] e);
    chk({tag, " x0"}, x0, e[319:256]);
    chk({tag, " x1"}, x1, e[255:192]);
    chk({tag, " x2"}, x2, e[191:128]);
    chk({tag, " x3"}, x3, e[127:64]);
    chk({tag, " x4"}, x4, e[63:0]);
  endtask

  // One request on the shared bus; leaves all instances in DONE.
  task automatic array_run(input logic [1:0] s, input logic [127:0] k, input logic [127:0] n);
    logic [319:0] e;
    int lat;
    e = ref_perm(s, k, n);
    m_sel = s; m_key = k; m_nonce = n; m_out_ready = 1'b0;
    for (int g = 0; g < 5; g++) chk($sformatf("rpc%0d in_ready", rpc_of(g)), 64'(a_in_ready[g]), 1);
    m_in_valid = 1'b1;
    tick(1);
    m_in_valid = 1'b0;
    m_key = ~k;
    m_nonce = ~n;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick(1);
      for (int g = 0; g < 5; g++) begin
        lat = 12 / int'(rpc_of(g));
        chk($sformatf("rpc%0d out_valid c%0d", rpc_of(g), cyc), 64'(a_ov[g]), 64'(cyc >= lat));
        chk($sformatf("rpc%0d busy c%0d", rpc_of(g), cyc), 64'(a_busy[g]), 64'(cyc < lat));
      end
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rpc%0d out_type", rpc_of(g)), 64'(a_type[g]), 64'(s));
      for (int wi = 0; wi < 5; wi++)
        chk($sformatf("rpc%0d sel%0d x%0d", rpc_of(g), s, wi), a_x[g][wi], e[319-64*wi -: 64]);
    end
  endtask

  task automatic array_release();
    m_out_ready = 1'b1;
    tick(1);
    m_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] e;
    int lat;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst in_ready", 64'(in_ready), 0);
    chk("rst out_valid", 64'(out_valid), 0);
    chk("rst busy", 64'(busy), 0);
    chk("rst out_type", 64'(out_type), 0);
    chk("rst x0", x0, 0);
    chk("rst x4", x4, 0);
    #19 rst_n = 1'b1;
    #1 chk("post-rst in_ready low", 64'(in_ready), 0);
    tick(1);
    chk("post-rst in_ready high", 64'(in_ready), 1);

    // Hash, RPC=1
    sel = 2'd2; key = 128'hdeadbeef_01234567_89abcdef_cafef00d; nonce = ~key;
    out_ready = 1'b1; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    chk("hash busy", 64'(busy), 1);
    wait_valid(lat);
    chk("hash latency", 64'(lat), 12);
    chk_words("hash", HashExp);
    chk("hash out_type", 64'(out_type), 2);
    chk("hash busy done", 64'(busy), 0);
    tick(1);
    chk("hash released", 64'(out_valid), 0);

    // AEAD-128 with backpressure, then back-to-back Hash
    e = ref_perm(2'd0, KeySeq, KeySeq);
    sel = 2'd0; key = KeySeq; nonce = KeySeq; out_ready = 1'b0; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("aead128 latency", 64'(lat), 12);
    chk_words("aead128", e);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("hold%0d out_valid", i), 64'(out_valid), 1);
      chk($sformatf("hold%0d in_ready", i), 64'(in_ready), 0);
      chk($sformatf("hold%0d x0", i), x0, e[319:256]);
      chk($sformatf("hold%0d x3", i), x3, e[127:64]);
    end
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b in_ready", 64'(in_ready), 1);
    tick(1);
    in_valid = 1'b0;
    chk("b2b out_valid drop", 64'(out_valid), 0);
    chk("b2b busy", 64'(busy), 1);
    wait_valid(lat);
    chk("b2b latency", 64'(lat), 12);
    chk("b2b out_type", 64'(out_type), 2);
    chk_words("b2b hash", HashExp);
    tick(1);

    // Busy rejection: request held with changing inputs during RUN
    e = ref_perm(2'd1, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h1111222233334444aaaabbbbccccdddd);
    sel = 2'd1; key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    nonce = 128'h1111222233334444aaaabbbbccccdddd; in_valid = 1'b1;
    tick(1);
    chk("rej busy", 64'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rej%0d in_ready", i), 64'(in_ready), 0);
      key = {$urandom, $urandom, $urandom, $urandom};
      nonce = {$urandom, $urandom, $urandom, $urandom};
      sel = 2'd3;
      tick(1);
    end
    wait_valid(lat);
    in_valid = 1'b0;
    chk("rej latency", 64'(lat), 7);
    chk("rej out_type", 64'(out_type), 1);
    chk_words("rej aead128a", e);
    tick(1);

    // Multi-RPC AEAD and XOF
    array_run(2'd0, KeySeq, KeySeq);
    array_release();
    array_run(2'd1, KeySeq, KeySeq);
    array_release();
    array_run(2'd0, '0, '0);
    array_release();
    array_run(2'd1, '0, '0);
    array_release();
    array_run(2'd3, KeySeq, KeySeq);
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rpc%0d xof x0 const", rpc_of(g)), a_x[g][0], 64'hb57e273b814cd416);
      chk($sformatf("rpc%0d xof x4 const", rpc_of(g)), a_x[g][4], 64'h4f3e0e32539493b6);
    end
    array_release();

    // Mid-run asynchronous reset
    sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(4);
    chk("mid busy before rst", 64'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst busy", 64'(busy), 0);
    chk("mid rst out_valid", 64'(out_valid), 0);
    chk("mid rst out_type", 64'(out_type), 0);
    chk("mid rst x0", x0, 0);
    chk("mid rst x2", x2, 0);
    chk("mid rst in_ready", 64'(in_ready), 0);
    #2 rst_n = 1'b1;
    #1 chk("mid rel in_ready low", 64'(in_ready), 0);
    tick(1);
    chk("mid rel in_ready high", 64'(in_ready), 1);
    chk("mid rel out_valid", 64'(out_valid), 0);
    sel = 2'd2; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("post-rst hash latency", 64'(lat), 12);
    chk_words("post-rst hash", HashExp);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
